// File: rtl/g_item_mover_if.sv
// Item mover bus: game-side strobes and character/scroll inputs, renderer/score-side outputs.
interface g_item_mover_if;
    logic       frame_tick;
    logic       spawn;
    logic [9:0] char_X;
    logic [9:0] char_Y;
    logic [9:0] bg_pos;
    logic [9:0] item_x;
    logic [9:0] item_y;
    logic       touch;
    logic       en;
    logic [1:0] state;

    modport master (
        output frame_tick, spawn, char_X, char_Y, bg_pos,
        input  item_x, item_y, touch, en, state
    );

    modport slave (
        input  frame_tick, spawn, char_X, char_Y, bg_pos,
        output item_x, item_y, touch, en, state
    );
endinterface

// File: rtl/g_item_mover.sv
// Moving power-up item: hidden -> emerges from block -> slides/bounces/falls -> collected on overlap.
// Motion steps on frame_tick; collection yields a registered one-cycle touch pulse.
module g_item_mover #(
    parameter int ITEM_W   = 12,
    parameter int ITEM_H   = 12,
    parameter int CHAR_W   = 12,
    parameter int CHAR_H   = 12,
    parameter int SPAWN_X  = 317,
    parameter int SPAWN_Y  = 135,
    parameter int GROUND_Y = 200,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 1000,
    parameter int SPEED    = 1,
    parameter int FALL     = 2
) (
    input  logic           sys_clk,
    input  logic           RST,
    g_item_mover_if.slave  io
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMERGE = 2'd1,
        MOVE   = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int CNT_W = $clog2(ITEM_H + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITEM_H - 1);
    localparam logic [9:0]  SPAWN_X10  = 10'(SPAWN_X);
    localparam logic [9:0]  SPAWN_Y10  = 10'(SPAWN_Y);
    localparam logic [9:0]  GROUND10   = 10'(GROUND_Y);
    localparam logic [9:0]  X_RIGHT10  = 10'(X_MAX - ITEM_W);
    localparam logic [9:0]  X_LEFT10   = 10'(X_MIN);
    localparam logic [9:0]  SPEED10    = 10'(SPEED);
    localparam logic [9:0]  FALL10     = 10'(FALL);
    localparam logic [10:0] X_RIGHT11  = 11'(X_MAX - ITEM_W);
    localparam logic [10:0] X_LEFT11   = 11'(X_MIN);
    localparam logic [10:0] SPEED11    = 11'(SPEED);
    localparam logic [10:0] ITEM_W11   = 11'(ITEM_W);
    localparam logic [10:0] ITEM_H11   = 11'(ITEM_H);
    localparam logic [10:0] CHAR_W11   = 11'(CHAR_W);
    localparam logic [10:0] CHAR_H11   = 11'(CHAR_H);

    state_e           state_q, state_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             touch_q, touch_d;

    logic             active;
    logic             hit;
    logic             overlap;
    logic [9:0]       ground_gap;

    // Bounding-box test at 11 bits so edge sums near 1023 do not wrap.
    assign active = (state_q == EMERGE) || (state_q == MOVE);
    assign hit    = ({1'b0, io.char_X} <= ({1'b0, x_q} + ITEM_W11))
                 && (({1'b0, io.char_X} + CHAR_W11) >= {1'b0, x_q})
                 && ({1'b0, io.char_Y} <= ({1'b0, y_q} + ITEM_H11))
                 && (({1'b0, io.char_Y} + CHAR_H11) >= {1'b0, y_q});
    assign overlap = active && hit;

    assign ground_gap = GROUND10 - y_q;

    always_ff @(posedge sys_clk) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (io.spawn) begin
                    state_d = EMERGE;
                end
            end
            EMERGE: begin
                if (overlap) begin
                    state_d = DONE;
                end else if (io.frame_tick && (cnt_q == CNT_LAST)) begin
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (overlap) begin
                    state_d = DONE;
                end
            end
            default: state_d = DONE;
        endcase
    end

    always_comb begin
        io.en    = active;
        io.state = state_q;
        io.touch = touch_q;
        io.item_x = x_q - io.bg_pos;
        io.item_y = y_q;
    end

    // Overlap suppresses motion in the same cycle; spawn only matters in IDLE.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        touch_d = overlap;
        if (state_q == IDLE) begin
            if (io.spawn) begin
                x_d   = SPAWN_X10;
                y_d   = SPAWN_Y10;
                dir_d = 1'b1;
                cnt_d = '0;
            end
        end else if (!overlap && io.frame_tick) begin
            if (state_q == EMERGE) begin
                y_d   = y_q - 10'd1;
                cnt_d = cnt_q + 1'b1;
            end else if (state_q == MOVE) begin
                if (dir_q) begin
                    if (({1'b0, x_q} + SPEED11) > X_RIGHT11) begin
                        x_d   = X_RIGHT10;
                        dir_d = 1'b0;
                    end else begin
                        x_d = x_q + SPEED10;
                    end
                end else begin
                    if ({1'b0, x_q} < (X_LEFT11 + SPEED11)) begin
                        x_d   = X_LEFT10;
                        dir_d = 1'b1;
                    end else begin
                        x_d = x_q - SPEED10;
                    end
                end
                if (y_q < GROUND10) begin
                    if (ground_gap < FALL10) begin
                        y_d = GROUND10;
                    end else begin
                        y_d = y_q + FALL10;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (RST) begin
            x_q     <= SPAWN_X10;
            y_q     <= SPAWN_Y10;
            dir_q   <= 1'b1;
            cnt_q   <= '0;
            touch_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            touch_q <= touch_d;
        end
    end

endmodule

// File: tb/tb_g_item_mover.sv
// Directed bench for g_item_mover: reset, emerge, bounce at X_MAX=340, ground clamp, collision, re-reset.
module tb_g_item_mover;

    logic sys_clk;
    logic RST;
    int   checks;
    int   errors;

    g_item_mover_if io();

    g_item_mover #(
        .X_MAX    (340),
        .GROUND_Y (200)
    ) dut (
        .sys_clk (sys_clk),
        .RST     (RST),
        .io      (io)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given strobes; outputs are stable on return.
    task automatic cyc(input logic t, input logic s);
        @(negedge sys_clk);
        io.frame_tick = t;
        io.spawn      = s;
        @(posedge sys_clk);
        #1;
        io.frame_tick = 1'b0;
        io.spawn      = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge sys_clk);
        RST = 1'b1;
        @(posedge sys_clk);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        RST           = 1'b1;
        io.frame_tick = 1'b0;
        io.spawn      = 1'b0;
        io.char_X     = 10'd0;
        io.char_Y     = 10'd0;
        io.bg_pos     = 10'd17;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        RST = 1'b0;

        chk("rst_state", io.state, 0);
        chk("rst_en", io.en, 0);
        chk("rst_touch", io.touch, 0);
        chk("rst_item_y", io.item_y, 135);
        chk("rst_item_x", io.item_x, 300);
        io.bg_pos = 10'd400;
        #1;
        chk("item_x_wrap", io.item_x, 941);
        io.bg_pos = 10'd0;

        cyc(1'b1, 1'b0);
        chk("idle_tick_state", io.state, 0);
        chk("idle_tick_y", io.item_y, 135);

        cyc(1'b0, 1'b1);
        chk("spawn_state", io.state, 1);
        chk("spawn_en", io.en, 1);
        cyc(1'b0, 1'b0);
        chk("no_tick_y", io.item_y, 135);

        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, 1'b0);
            chk($sformatf("emerge_y%0d", i), io.item_y, 135 - i);
            chk($sformatf("emerge_x%0d", i), io.item_x, 317);
            if (i == 11) chk("emerge_state11", io.state, 1);
        end
        chk("emerge_done_state", io.state, 2);

        cyc(1'b1, 1'b0);
        chk("t13_x", io.item_x, 318);
        chk("t13_y", io.item_y, 125);

        run_ticks(10);
        chk("t23_x", io.item_x, 328);
        chk("t23_y", io.item_y, 145);
        cyc(1'b1, 1'b0);
        chk("t24_x_clamp", io.item_x, 328);
        chk("t24_y", io.item_y, 147);
        cyc(1'b1, 1'b0);
        chk("t25_x_back", io.item_x, 327);
        chk("t25_y", io.item_y, 149);

        run_ticks(25);
        chk("t50_y", io.item_y, 199);
        chk("t50_x", io.item_x, 302);
        cyc(1'b1, 1'b0);
        chk("t51_y_clamp", io.item_y, 200);
        chk("t51_x", io.item_x, 301);
        cyc(1'b1, 1'b0);
        chk("t52_y_hold", io.item_y, 200);
        chk("t52_x", io.item_x, 300);

        io.char_X = 10'd313;
        io.char_Y = 10'd200;
        cyc(1'b0, 1'b0);
        chk("near_miss_touch", io.touch, 0);
        chk("near_miss_state", io.state, 2);

        io.char_X = 10'd312;
        cyc(1'b1, 1'b0);
        chk("hit_touch", io.touch, 1);
        chk("hit_en", io.en, 0);
        chk("hit_state", io.state, 3);
        chk("hit_x_frozen", io.item_x, 300);
        chk("hit_y_frozen", io.item_y, 200);
        cyc(1'b0, 1'b0);
        chk("touch_one_cycle", io.touch, 0);
        cyc(1'b1, 1'b1);
        chk("done_spawn_ignored", io.state, 3);
        chk("done_en", io.en, 0);
        chk("done_touch", io.touch, 0);

        pulse_reset();
        chk("rst_done_state", io.state, 0);
        io.char_X = 10'd0;
        io.char_Y = 10'd0;
        cyc(1'b0, 1'b1);
        run_ticks(14);
        chk("mid_move_state", io.state, 2);
        chk("mid_move_x", io.item_x, 319);
        pulse_reset();
        chk("rst_mid_state", io.state, 0);
        chk("rst_mid_en", io.en, 0);
        chk("rst_mid_x", io.item_x, 317);
        chk("rst_mid_y", io.item_y, 135);
        cyc(1'b0, 1'b1);
        chk("respawn_state", io.state, 1);
        chk("respawn_x", io.item_x, 317);
        chk("respawn_y", io.item_y, 135);
        cyc(1'b1, 1'b0);
        chk("respawn_rise", io.item_y, 134);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
